// File: rtl/maze_pkg.sv
// Shared maze geometry, direction bit indices and controller FSM encodings.
// Used by player_move_controller and the move detector.
package maze_pkg;

   localparam int ORIGIN_X  = 336;
   localparam int ORIGIN_Y  = 27;
   localparam int CELL_PX   = 16;
   localparam int CENTER_PX = 7;
   localparam int GRID_W    = 32;
   localparam int GRID_H    = 32;

   // Bit positions inside a 4-bit direction vector (dir_req / valid_moves)
   localparam int DIR_RIGHT = 0;
   localparam int DIR_UP    = 1;
   localparam int DIR_DOWN  = 2;
   localparam int DIR_LEFT  = 3;

   // Controller FSM encodings
   localparam logic [1:0] ST_SETTLE = 2'd0;
   localparam logic [1:0] ST_IDLE   = 2'd1;
   localparam logic [1:0] ST_MOVE   = 2'd2;

   // True when exactly one direction bit is set
   function automatic logic is_onehot4(input logic [3:0] v);
      return ($countones(v) == 1);
   endfunction

endpackage

// File: rtl/move_step_counter.sv
// Frame-tick gated step counter: counts 0..CELL_PX-1 on tick_i and raises
// term_o combinationally on the tick that completes the last step.
// clr_i holds the counter at zero while the player is not moving.
module move_step_counter #(
   parameter int CELL_PX = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic tick_i,
   output logic term_o
);

   localparam int CW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
   localparam logic [CW-1:0] LAST = CW'(CELL_PX - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign term_o = tick_i && !clr_i && (cnt_q == LAST);

   // Next count: clear, wrap after the last step, or advance on a tick
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (tick_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   // Count register
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/player_move_controller.sv
// Player movement controller: SETTLE -> IDLE -> MOVE -> SETTLE.
// In IDLE a single legal, in-grid direction request starts a one-cell move
// that advances one pixel per frame_tick; arrival updates the cell, pulses
// move_done and re-enters SETTLE so the move detector can catch up.
// Optional feature: define MOVE_QUEUE_EN to keep one pending request that
// is captured during MOVE and tried once when the controller reaches IDLE.
//
// Handshake: there is no backpressure. dir_req is only sampled in IDLE
// (and captured into the pending slot during MOVE when MOVE_QUEUE_EN is
// defined); a request is consumed on the cycle it is accepted.
module player_move_controller #(
   parameter int ORIGIN_X   = maze_pkg::ORIGIN_X,
   parameter int ORIGIN_Y   = maze_pkg::ORIGIN_Y,
   parameter int CELL_PX    = maze_pkg::CELL_PX,
   parameter int CENTER_PX  = maze_pkg::CENTER_PX,
   parameter int GRID_W     = maze_pkg::GRID_W,
   parameter int GRID_H     = maze_pkg::GRID_H,
   parameter int START_COL  = 1,
   parameter int START_ROW  = 1,
   parameter int DETECT_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic [3:0]  dir_req,
   input  logic [3:0]  valid_moves,
   output logic [10:0] display_pos_x,
   output logic [9:0]  display_pos_y,
   output logic [4:0]  cell_col,
   output logic [4:0]  cell_row,
   output logic        moving,
   output logic        move_done,
   output logic [1:0]  state_dbg_o
);
   import maze_pkg::*;

   localparam logic [10:0] RST_X    = 11'(ORIGIN_X + START_COL * CELL_PX + CENTER_PX);
   localparam logic [9:0]  RST_Y    = 10'(ORIGIN_Y + START_ROW * CELL_PX + CENTER_PX);
   localparam logic [4:0]  RST_COL  = 5'(START_COL);
   localparam logic [4:0]  RST_ROW  = 5'(START_ROW);
   localparam logic [7:0]  LAT_LAST = 8'(DETECT_LAT - 1);

   logic [1:0]  state_q, state_d;
   logic [7:0]  settle_q, settle_d;
   logic        entry_q, entry_d;   // first cycle in MOVE: ticks do not count
   logic [3:0]  dir_q, dir_d;
   logic [10:0] x_q, x_d;
   logic [9:0]  y_q, y_d;
   logic [4:0]  col_q, col_d;
   logic [4:0]  row_q, row_d;
   logic        done_q, done_d;
`ifdef MOVE_QUEUE_EN
   logic [3:0]  pend_q, pend_d;
   logic        pend_ok;
`endif

   logic [3:0]  bound_ok;
   logic        live_ok;
   logic        step_tick;
   logic        step_term;

   // Which neighbouring cells lie inside the grid
   always_comb begin
      bound_ok            = '0;
      bound_ok[DIR_RIGHT] = (int'(col_q) < GRID_W - 1);
      bound_ok[DIR_LEFT]  = (col_q != 5'd0);
      bound_ok[DIR_UP]    = (row_q != 5'd0);
      bound_ok[DIR_DOWN]  = (int'(row_q) < GRID_H - 1);
   end

   assign live_ok = is_onehot4(dir_req) && (|(dir_req & valid_moves & bound_ok));
`ifdef MOVE_QUEUE_EN
   assign pend_ok = |(pend_q & valid_moves & bound_ok);
`endif

   assign step_tick = frame_tick && (state_q == ST_MOVE) && !entry_q;

   move_step_counter #(.CELL_PX(CELL_PX)) u_step (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (state_q != ST_MOVE),
      .tick_i (step_tick),
      .term_o (step_term)
   );

   // FSM next state, pixel stepping and cell update on arrival
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      entry_d  = 1'b0;
      dir_d    = dir_q;
      x_d      = x_q;
      y_d      = y_q;
      col_d    = col_q;
      row_d    = row_q;
      done_d   = 1'b0;
`ifdef MOVE_QUEUE_EN
      pend_d   = pend_q;
`endif
      case (state_q)
         ST_SETTLE: begin
            if (settle_q == LAT_LAST) begin
               settle_d = 8'd0;
               state_d  = ST_IDLE;
            end else begin
               settle_d = settle_q + 8'd1;
            end
         end
         ST_IDLE: begin
            if (live_ok) begin
               dir_d   = dir_req;
               state_d = ST_MOVE;
               entry_d = 1'b1;
            end
`ifdef MOVE_QUEUE_EN
            else if (pend_ok) begin
               dir_d   = pend_q;
               state_d = ST_MOVE;
               entry_d = 1'b1;
            end
            pend_d = 4'd0;
`endif
         end
         ST_MOVE: begin
`ifdef MOVE_QUEUE_EN
            if (is_onehot4(dir_req)) pend_d = dir_req;
`endif
            if (step_tick) begin
               if (dir_q[DIR_RIGHT]) x_d = x_q + 11'd1;
               if (dir_q[DIR_LEFT])  x_d = x_q - 11'd1;
               if (dir_q[DIR_UP])    y_d = y_q - 10'd1;
               if (dir_q[DIR_DOWN])  y_d = y_q + 10'd1;
            end
            if (step_term) begin
               if (dir_q[DIR_RIGHT]) col_d = col_q + 5'd1;
               if (dir_q[DIR_LEFT])  col_d = col_q - 5'd1;
               if (dir_q[DIR_UP])    row_d = row_q - 5'd1;
               if (dir_q[DIR_DOWN])  row_d = row_q + 5'd1;
               done_d   = 1'b1;
               settle_d = 8'd0;
               state_d  = ST_SETTLE;
            end
         end
         default: begin
            state_d  = ST_SETTLE;
            settle_d = 8'd0;
         end
      endcase
   end

   // State registers; reset wins over every other input
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_SETTLE;
         settle_q <= 8'd0;
         entry_q  <= 1'b0;
         dir_q    <= 4'd0;
         x_q      <= RST_X;
         y_q      <= RST_Y;
         col_q    <= RST_COL;
         row_q    <= RST_ROW;
         done_q   <= 1'b0;
`ifdef MOVE_QUEUE_EN
         pend_q   <= 4'd0;
`endif
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         entry_q  <= entry_d;
         dir_q    <= dir_d;
         x_q      <= x_d;
         y_q      <= y_d;
         col_q    <= col_d;
         row_q    <= row_d;
         done_q   <= done_d;
`ifdef MOVE_QUEUE_EN
         pend_q   <= pend_d;
`endif
      end
   end

   assign display_pos_x = x_q;
   assign display_pos_y = y_q;
   assign cell_col      = col_q;
   assign cell_row      = row_q;
   assign moving        = (state_q == ST_MOVE);
   assign move_done     = done_q;
   assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_player_move_controller.sv
// Directed bench for player_move_controller: reset values, per-pixel
// stepping, rejection cases, grid bounds, mid-move reset and (when
// MOVE_QUEUE_EN is defined) the pending-request slot.
module tb_player_move_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        frame_tick = 1'b0;
   logic [3:0]  dir_req = 4'd0;
   logic [3:0]  valid_moves = 4'b1111;
   logic [10:0] display_pos_x;
   logic [9:0]  display_pos_y;
   logic [4:0]  cell_col;
   logic [4:0]  cell_row;
   logic        moving;
   logic        move_done;
   logic [1:0]  state_dbg;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [3:0]  dir;
      logic [3:0]  vm;
      logic        mv;
      logic [4:0]  col;
      logic [4:0]  row;
      logic [10:0] x;
      logic [9:0]  y;
   } vec_t;

   vec_t vecs[13];

   // Clock
   always #5 clk = ~clk;

   // Global time limit
   initial begin
      #400000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   player_move_controller dut (
      .clk           (clk),
      .rst           (rst),
      .frame_tick    (frame_tick),
      .dir_req       (dir_req),
      .valid_moves   (valid_moves),
      .display_pos_x (display_pos_x),
      .display_pos_y (display_pos_y),
      .cell_col      (cell_col),
      .cell_row      (cell_row),
      .moving        (moving),
      .move_done     (move_done),
      .state_dbg_o   (state_dbg)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reset pulse; returns on the negedge right after the reset edge
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; dir_req = 4'd0; frame_tick = 1'b0; valid_moves = 4'b1111;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // One frame_tick pulse; returns once the tick edge has taken effect
   task automatic tick_once();
      @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic check_pos(input string name, input int col, input int row, input int x, input int y);
      check({name, "_col"}, 32'(cell_col), 32'(col));
      check({name, "_row"}, 32'(cell_row), 32'(row));
      check({name, "_x"}, 32'(display_pos_x), 32'(x));
      check({name, "_y"}, 32'(display_pos_y), 32'(y));
   endtask

   initial begin
      vecs[0]  = '{4'b0001, 4'b1110, 1'b0, 5'd2, 5'd1, 11'd375, 10'd50};
      vecs[1]  = '{4'b0011, 4'b1111, 1'b0, 5'd2, 5'd1, 11'd375, 10'd50};
      vecs[2]  = '{4'b0000, 4'b1111, 1'b0, 5'd2, 5'd1, 11'd375, 10'd50};
      vecs[3]  = '{4'b1000, 4'b1111, 1'b1, 5'd1, 5'd1, 11'd359, 10'd50};
      vecs[4]  = '{4'b1000, 4'b1111, 1'b1, 5'd0, 5'd1, 11'd343, 10'd50};
      vecs[5]  = '{4'b0100, 4'b1111, 1'b1, 5'd0, 5'd2, 11'd343, 10'd66};
      vecs[6]  = '{4'b0100, 4'b1111, 1'b1, 5'd0, 5'd3, 11'd343, 10'd82};
      vecs[7]  = '{4'b0100, 4'b1111, 1'b1, 5'd0, 5'd4, 11'd343, 10'd98};
      vecs[8]  = '{4'b0100, 4'b1111, 1'b1, 5'd0, 5'd5, 11'd343, 10'd114};
      vecs[9]  = '{4'b1000, 4'b1111, 1'b0, 5'd0, 5'd5, 11'd343, 10'd114};
      vecs[10] = '{4'b0010, 4'b0100, 1'b0, 5'd0, 5'd5, 11'd343, 10'd114};
      vecs[11] = '{4'b0010, 4'b0010, 1'b1, 5'd0, 5'd4, 11'd343, 10'd98};
      vecs[12] = '{4'b0001, 4'b1111, 1'b1, 5'd1, 5'd4, 11'd359, 10'd98};

      // Reset values
      do_reset();
      check_pos("reset", 1, 1, 359, 50);
      check("reset_moving", 32'(moving), 32'd0);
      check("reset_done", 32'(move_done), 32'd0);

      // First right move; a tick coincident with entry into MOVE must not count
      cyc(3);
      dir_req = 4'b0001; frame_tick = 1'b1;
      @(negedge clk);
      dir_req = 4'b0000;
      check("entry_moving", 32'(moving), 32'd1);
      @(negedge clk);
      frame_tick = 1'b0;
      check("entry_tick_x", 32'(display_pos_x), 32'd359);
      for (int i = 0; i < 16; i++) begin
         tick_once();
         check("step_x", 32'(display_pos_x), 32'(360 + i));
         check("step_y", 32'(display_pos_y), 32'd50);
         check("step_done", 32'(move_done), (i == 15) ? 32'd1 : 32'd0);
         check("step_col", 32'(cell_col), (i == 15) ? 32'd2 : 32'd1);
      end
      check("arrive_moving", 32'(moving), 32'd0);
      @(negedge clk);
      check("done_pulse_end", 32'(move_done), 32'd0);

      // Table-driven requests from cell (2,1)
      for (int k = 0; k < 13; k++) begin
         cyc(3);
         dir_req = vecs[k].dir; valid_moves = vecs[k].vm;
         @(negedge clk);
         dir_req = 4'd0;
         check("vec_moving", 32'(moving), 32'(vecs[k].mv));
         if (vecs[k].mv) begin
            for (int i = 0; i < 16; i++) begin
               tick_once();
               check("vec_done", 32'(move_done), (i == 15) ? 32'd1 : 32'd0);
            end
         end else begin
            for (int i = 0; i < 20; i++) tick_once();
            check("vec_idle", 32'(moving), 32'd0);
         end
         check_pos("vec", int'(vecs[k].col), int'(vecs[k].row), int'(vecs[k].x), int'(vecs[k].y));
         valid_moves = 4'b1111;
      end

      // Reset in the middle of a right move
      do_reset();
      cyc(3);
      dir_req = 4'b0001;
      @(negedge clk);
      dir_req = 4'b0000;
      for (int i = 0; i < 5; i++) tick_once();
      check("midmove_x", 32'(display_pos_x), 32'd364);
      rst = 1'b1;
      @(negedge clk);
      check_pos("midreset", 1, 1, 359, 50);
      check("midreset_moving", 32'(moving), 32'd0);
      rst = 1'b0;

`ifdef MOVE_QUEUE_EN
      // Pending up request captured mid-move, accepted after settle
      do_reset();
      cyc(3);
      dir_req = 4'b0001;
      @(negedge clk);
      dir_req = 4'b0000;
      for (int i = 0; i < 16; i++) begin
         if (i == 7) dir_req = 4'b0010;
         tick_once();
         dir_req = 4'b0000;
      end
      check_pos("q_arrive", 2, 1, 375, 50);
      cyc(3);
      check("q_moving", 32'(moving), 32'd1);
      for (int i = 0; i < 16; i++) tick_once();
      check_pos("q_up", 2, 0, 375, 34);

      // Pending request rejected by valid_moves, then discarded
      do_reset();
      cyc(3);
      dir_req = 4'b0001;
      @(negedge clk);
      dir_req = 4'b0000;
      for (int i = 0; i < 16; i++) begin
         if (i == 7) dir_req = 4'b0010;
         if (i == 15) valid_moves = 4'b1101;
         tick_once();
         dir_req = 4'b0000;
      end
      cyc(3);
      check("qrej_moving", 32'(moving), 32'd0);
      for (int i = 0; i < 20; i++) tick_once();
      check_pos("qrej", 2, 1, 375, 50);
      valid_moves = 4'b1111;
      cyc(3);
      check("qrej_cleared", 32'(moving), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
